// File: rtl/vga_capture.sv
// Receive-side monitor for a TinyVGA PMOD stream: recovers sync timing, declares
// lock on nominal timing, and reports per-pixel data plus a per-frame checksum.
module vga_capture #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter bit          SYNC_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam int unsigned HX0 = H_SYNC + H_BACK;
  localparam int unsigned HX1 = HX0 + H_ACTIVE;
  localparam int unsigned VY0 = V_SYNC + V_BACK;
  localparam int unsigned VY1 = VY0 + V_ACTIVE;

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state;
  logic        hs1, vs1, hs_prev, vs_prev;
  logic [5:0]  rgb1, rgb2;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        hseen;
  logic [15:0] acc;

  logic hs_edge, vs_edge, line_fail, frame_fail, active, to_search;

  // hcnt/vcnt/rgb2 all describe the sample held one stage behind stage 1
  assign hs_edge    = hs1 & ~hs_prev;
  assign vs_edge    = vs1 & ~vs_prev;
  assign line_fail  = hs_edge & hseen & ((32'(hcnt) + 32'd1) != H_TOTAL);
  assign frame_fail = vs_edge & ((32'(vcnt) + 32'd1) != V_TOTAL);
  assign active     = (32'(hcnt) >= HX0) && (32'(hcnt) < HX1) &&
                      (32'(vcnt) >= VY0) && (32'(vcnt) < VY1);
  assign to_search  = ((state == CHECK) && line_fail) ||
                      ((state == LOCKED) && (line_fail || frame_fail));
  assign locked     = (state == LOCKED);

  // Input stage: syncs normalised to active-high, colour reordered to {R1,R0,G1,G0,B1,B0}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb1    <= '0;
      rgb2    <= '0;
    end else begin
      hs1     <= vga_in[7] ^ SYNC_LOW;
      vs1     <= vga_in[3] ^ SYNC_LOW;
      hs_prev <= hs1;
      vs_prev <= vs1;
      rgb1    <= {vga_in[0], vga_in[4], vga_in[1], vga_in[5], vga_in[2], vga_in[6]};
      rgb2    <= rgb1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt  <= '0;
      vcnt  <= '0;
      hseen <= 1'b0;
    end else begin
      if (hs_edge)                hcnt <= '0;
      else if (hcnt != 11'h7FF)   hcnt <= hcnt + 11'd1;
      if (vs_edge)                vcnt <= '0;
      else if (hs_edge && vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;
      if (to_search)              hseen <= 1'b0;
      else if (hs_edge)           hseen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      sync_err  <= 1'b0;
      err_count <= '0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        SEARCH: if (vs_edge) state <= CHECK;
        CHECK: begin
          if (line_fail)                    state <= SEARCH;
          else if (vs_edge && !frame_fail)  state <= LOCKED;
        end
        LOCKED: begin
          if (line_fail || frame_fail) begin
            state    <= SEARCH;
            sync_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Frame checksum; the running value is published only for clean locked frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      frame_sum  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (vs_edge) begin
        if (state == LOCKED && !frame_fail) begin
          frame_sum  <= acc;
          frame_done <= 1'b1;
        end
        acc <= '0;
      end else if (state != SEARCH && active) begin
        acc <= {acc[14:0], acc[15]} ^ {10'b0, rgb2};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      pix_valid <= active && (state == LOCKED);
      if (active && (state == LOCKED)) begin
        pix_x   <= 10'(32'(hcnt) - HX0);
        pix_y   <= 10'(32'(vcnt) - VY0);
        pix_rgb <= rgb2;
      end
    end
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side monitor for the demo's TinyVGA PMOD output (`uo_out` pinout).
- Recovers horizontal and vertical timing from the sync pulses, then declares lock once the timing matches nominal.
- While locked, it emits per-pixel coordinates and colour, and a 16-bit checksum per frame.
- Used in benches and on-chip self-test to check the generator end to end.

Parameters:
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, back porch in clocks
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, back porch in lines
- V_ACTIVE, 480, active lines
- V_TOTAL, 525, lines per frame
- SYNC_LOW, 1, sync polarity: 1 = sync pulses are active low

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, reset, active low, asynchronous
- vga_in, input, 8, PMOD bits: [7]HS, [6]B0, [5]G0, [4]R0, [3]VS, [2]B1, [1]G1, [0]R1
- pix_valid, output, 1, active pixel strobe (only while locked)
- pix_x, output, 10, active column 0..H_ACTIVE-1
- pix_y, output, 10, active row 0..V_ACTIVE-1
- pix_rgb, output, 6, colour as {R1,R0,G1,G0,B1,B0}
- locked, output, 1, timing lock
- frame_done, output, 1, one-cycle pulse when frame_sum updates
- frame_sum, output, 16, checksum of the last complete locked frame
- sync_err, output, 1, one-cycle pulse when lock is lost
- err_count, output, 8, count of lock losses, saturating at 255

Behaviour:
- Reset: all outputs, counters, accumulator and err_count are 0; FSM state is SEARCH.
- Stage 1 registers vga_in; sync signals are normalised to active-high (inverted when SYNC_LOW=1).
- Edge detection:
  - hs_edge: stage-1 HS is asserted and the previous sample was deasserted.
  - vs_edge: same rule applied to VS.
- hcnt (11 bits):
  - Set to 0 on hs_edge.
  - Otherwise incremented, saturating at 2047.
- vcnt (10 bits):
  - Set to 0 on vs_edge; vs_edge has priority over a coincident hs_edge.
  - Otherwise incremented on hs_edge, saturating at 1023.
- Line check:
  - Applied on hs_edge when the hseen flag is set; fails if old hcnt+1 != H_TOTAL.
  - hseen is cleared on reset and on entry to SEARCH, and set on every hs_edge.
- Frame check: applied on vs_edge; fails if old vcnt+1 != V_TOTAL.
- FSM:
  - SEARCH: performs no checks; a vs_edge moves to CHECK.
  - CHECK:
    - Line-check failure: go to SEARCH.
    - vs_edge with passing frame check: go to LOCKED.
    - vs_edge with failing frame check: stay in CHECK (restart).
  - LOCKED, on line or frame check failure:
    - Go to SEARCH.
    - Pulse sync_err for one cycle.
    - Increment err_count (saturating).
  - locked = (state == LOCKED).
- Active region:
  - Horizontal: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE).
  - Vertical: vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - pix_x = hcnt-(H_SYNC+H_BACK); pix_y = vcnt-(V_SYNC+V_BACK).
- Pixel output timing:
  - Outputs are registered; a sample at vga_in on edge N appears on the pixel outputs after edge N+2.
  - pix_valid = active && locked.
  - pix_x, pix_y and pix_rgb hold their last value when pix_valid is low.
- Checksum:
  - In CHECK and LOCKED, each active pixel updates acc <= rotl16(acc,1) ^ {10'b0, rgb}.
  - On vs_edge, if the state was LOCKED and the frame check passes: frame_sum <= acc and frame_done pulses.
  - acc is cleared on every vs_edge, after the capture above.
  - Lock loss does not change frame_sum.
- A reset mid-frame returns everything to the reset state immediately.
- Colour bits are ignored outside the active region.

Test Plan:
- Ideal 640x480 stream, reset applied mid-line:
  - locked rises on the second vs_edge after reset.
  - First pix_valid carries x=0, y=0 and appears 2 cycles after the sample with hcnt=144 and vcnt=35.
- All pixels 0 except (0,0)=6'h01, three locked frames:
  - frame_sum = 0x8000 each frame, since the pixel is rotated 307199 times and 307199 mod 16 = 15.
  - frame_done pulses once per frame.
- All pixels 6'h3F: frame_sum = 0x0000 (307200 pixels is a multiple of 16).
- While locked, a single line of 799 clocks:
  - sync_err pulses once, err_count=1, locked falls and pix_valid stops.
  - Lock is re-acquired two vs_edges later.
- One frame of 524 lines while in CHECK: stays in CHECK with no sync_err; the next correct frame gives locked=1.
- SYNC_LOW=0 build with inverted syncs: same results as the first scenario.
- 256+ forced lock losses: err_count saturates at 255.
